// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and digit limits for the centisecond stopwatch
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        LAP     = 2'd3
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    // Field order matches the 24-bit display word, most significant digit first.
    typedef struct packed {
        bcd_digit_t min_tens;
        bcd_digit_t min_ones;
        bcd_digit_t sec_tens;
        bcd_digit_t sec_ones;
        bcd_digit_t cs_tens;
        bcd_digit_t cs_ones;
    } time_bcd_t;

    // Every decimal digit except seconds-tens and minutes-tens runs 0-9.
    localparam int CS_DIGIT_MAX = 9;
    localparam int SEC_TENS_MAX = 5;

endpackage

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - one wrapping BCD digit with ripple carry for the time cascade
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       inc,
    output bcd_digit_t digit,
    output logic       carry
);

    localparam bcd_digit_t MAX_D = bcd_digit_t'(MAX);

    // Carry is combinational so the whole chain rolls over on the same edge.
    assign carry = inc && (digit == MAX_D);

    // Digit register; the >= guard keeps an out-of-range value from ever persisting.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc) begin
            digit <= (digit >= MAX_D) ? '0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_controller.sv
// rtl/stopwatch_controller.sv - stopwatch FSM, BCD time cascade, lap snapshot and divider restart
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter bit SYNC_ON_RESUME  = 1'b1,
    parameter int MINUTE_TENS_MAX = 5
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        tick_in,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic        tick_restart,
    output logic        running,
    output logic        lap_active,
    output logic        overflow,
    output logic [23:0] time_bcd,
    output logic [23:0] disp_bcd
);

    state_t    state;
    state_t    state_next;
    time_bcd_t live;
    time_bcd_t lap_reg;
    logic [5:0] carry;
    logic      count_en;
    logic      restart_next;
    logic      lap_capture;

    // Ticks count only while the current state is a counting one; clear always wins.
    assign count_en = tick_in && !clear && ((state == RUNNING) || (state == LAP));

    // A restart pulse follows a start from IDLE, and optionally a resume from PAUSED.
    assign restart_next = start_stop && !clear &&
                          ((state == IDLE) || (SYNC_ON_RESUME && (state == PAUSED)));

    // The snapshot takes the value held before any coincident tick lands.
    assign lap_capture = lap && !clear && !start_stop && (state == RUNNING);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode with clear > start_stop > lap priority.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else if (start_stop) begin
            case (state)
                IDLE, PAUSED: state_next = RUNNING;
                RUNNING, LAP: state_next = PAUSED;
                default:      state_next = IDLE;
            endcase
        end else if (lap) begin
            case (state)
                RUNNING: state_next = LAP;
                LAP:     state_next = RUNNING;
                default: state_next = state;
            endcase
        end
    end

    // Status outputs decoded straight from the current state.
    always_comb begin
        running    = 1'b0;
        lap_active = 1'b0;
        case (state)
            RUNNING: running = 1'b1;
            LAP: begin
                running    = 1'b1;
                lap_active = 1'b1;
            end
            default: begin
                running    = 1'b0;
                lap_active = 1'b0;
            end
        endcase
    end

    // One-cycle restart pulse to the divider enable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_restart <= 1'b0;
        end else begin
            tick_restart <= restart_next;
        end
    end

    // Lap snapshot register, zeroed by clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lap_reg <= '0;
        end else if (clear) begin
            lap_reg <= '0;
        end else if (lap_capture) begin
            lap_reg <= live;
        end
    end

    // Sticky overflow: set when the top digit carries out, held until clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (carry[5]) begin
            overflow <= 1'b1;
        end
    end

    bcd_digit_counter #(.MAX(CS_DIGIT_MAX)) u_cs_ones (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clear),
        .inc     (count_en),
        .digit   (live.cs_ones),
        .carry   (carry[0])
    );

    bcd_digit_counter #(.MAX(CS_DIGIT_MAX)) u_cs_tens (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clear),
        .inc     (carry[0]),
        .digit   (live.cs_tens),
        .carry   (carry[1])
    );

    bcd_digit_counter #(.MAX(CS_DIGIT_MAX)) u_sec_ones (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clear),
        .inc     (carry[1]),
        .digit   (live.sec_ones),
        .carry   (carry[2])
    );

    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clear),
        .inc     (carry[2]),
        .digit   (live.sec_tens),
        .carry   (carry[3])
    );

    bcd_digit_counter #(.MAX(CS_DIGIT_MAX)) u_min_ones (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clear),
        .inc     (carry[3]),
        .digit   (live.min_ones),
        .carry   (carry[4])
    );

    bcd_digit_counter #(.MAX(MINUTE_TENS_MAX)) u_min_tens (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clear),
        .inc     (carry[4]),
        .digit   (live.min_tens),
        .carry   (carry[5])
    );

    assign time_bcd = live;
    assign disp_bcd = lap_active ? lap_reg : live;

endmodule

// File: tb/tb_stopwatch_controller.sv
// tb/tb_stopwatch_controller.sv - table, directed and random checks against a centisecond-count model
module tb_stopwatch_controller;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_LAP   = 3;

    logic        clock;
    logic        reset_n;
    logic        tick_in;
    logic        start_stop;
    logic        lap;
    logic        clear;
    logic        tr_o   [2];
    logic        run_o  [2];
    logic        lapa_o [2];
    logic        ovf_o  [2];
    logic [23:0] time_o [2];
    logic [23:0] disp_o [2];

    int n_vec = 0;
    int n_bad = 0;

    // Model: time as a plain count of centiseconds modulo full scale.
    int m_st  [2];
    int m_cnt [2];
    int m_lap [2];
    bit m_ovf [2];
    bit m_rst [2];
    bit m_sync[2] = '{1'b1, 1'b0};
    int m_fs  [2] = '{360000, 60000};

    typedef struct {
        logic        t, ss, lp, cl;
        logic [23:0] exp_time;
        logic        exp_run, exp_lapa, exp_tr;
        logic [23:0] exp_disp;
    } vec_t;

    vec_t tbl [15];

    stopwatch_controller #(.SYNC_ON_RESUME(1'b1), .MINUTE_TENS_MAX(5)) u0 (
        .clock(clock), .reset_n(reset_n), .tick_in(tick_in), .start_stop(start_stop),
        .lap(lap), .clear(clear), .tick_restart(tr_o[0]), .running(run_o[0]),
        .lap_active(lapa_o[0]), .overflow(ovf_o[0]), .time_bcd(time_o[0]), .disp_bcd(disp_o[0])
    );

    stopwatch_controller #(.SYNC_ON_RESUME(1'b0), .MINUTE_TENS_MAX(0)) u1 (
        .clock(clock), .reset_n(reset_n), .tick_in(tick_in), .start_stop(start_stop),
        .lap(lap), .clear(clear), .tick_restart(tr_o[1]), .running(run_o[1]),
        .lap_active(lapa_o[1]), .overflow(ovf_o[1]), .time_bcd(time_o[1]), .disp_bcd(disp_o[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [23:0] to_bcd(int c);
        int m, s, cs;
        m  = c / 6000;
        s  = (c / 100) % 60;
        cs = c % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    task automatic chk(string name, int idx, logic [23:0] act, logic [23:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s u%0d: got %h expected %h at %0t", name, idx, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = M_IDLE; m_cnt[i] = 0; m_lap[i] = 0; m_ovf[i] = 0; m_rst[i] = 0;
        end
    endfunction

    function automatic void model_step(int i, logic t, logic ss, logic lp, logic cl);
        int old_st;
        old_st   = m_st[i];
        m_rst[i] = 0;
        if (cl) begin
            m_st[i] = M_IDLE; m_cnt[i] = 0; m_lap[i] = 0; m_ovf[i] = 0;
        end else begin
            if (ss) begin
                if (old_st == M_IDLE) begin
                    m_st[i] = M_RUN; m_rst[i] = 1;
                end else if (old_st == M_PAUSE) begin
                    m_st[i] = M_RUN; m_rst[i] = m_sync[i];
                end else begin
                    m_st[i] = M_PAUSE;
                end
            end else if (lp) begin
                if (old_st == M_RUN) begin
                    m_st[i] = M_LAP; m_lap[i] = m_cnt[i];
                end else if (old_st == M_LAP) begin
                    m_st[i] = M_RUN;
                end
            end
            if (t && (old_st == M_RUN || old_st == M_LAP)) begin
                m_cnt[i]++;
                if (m_cnt[i] == m_fs[i]) begin
                    m_cnt[i] = 0; m_ovf[i] = 1;
                end
            end
        end
    endfunction

    task automatic check_models();
        for (int i = 0; i < 2; i++) begin
            chk("time_bcd", i, time_o[i], to_bcd(m_cnt[i]));
            chk("disp_bcd", i, disp_o[i], (m_st[i] == M_LAP) ? to_bcd(m_lap[i]) : to_bcd(m_cnt[i]));
            chk("running", i, 24'(run_o[i]), 24'(m_st[i] == M_RUN || m_st[i] == M_LAP));
            chk("lap_active", i, 24'(lapa_o[i]), 24'(m_st[i] == M_LAP));
            chk("overflow", i, 24'(ovf_o[i]), 24'(m_ovf[i]));
            chk("tick_restart", i, 24'(tr_o[i]), 24'(m_rst[i]));
        end
    endtask

    task automatic cycle(input logic t, input logic ss, input logic lp, input logic cl);
        tick_in = t; start_stop = ss; lap = lp; clear = cl;
        @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) model_step(i, t, ss, lp, cl);
        check_models();
    endtask

    task automatic run_ticks(int n);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; tick_in = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
        model_reset();

        //               t  ss lp cl  time        run lapa tr  disp
        tbl[0]  = '{1'b0,1'b1,1'b0,1'b0, 24'h000000, 1'b1,1'b0,1'b1, 24'h000000};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b0, 24'h000001, 1'b1,1'b0,1'b0, 24'h000001};
        tbl[2]  = '{1'b1,1'b0,1'b1,1'b0, 24'h000002, 1'b1,1'b1,1'b0, 24'h000001};
        tbl[3]  = '{1'b1,1'b0,1'b0,1'b0, 24'h000003, 1'b1,1'b1,1'b0, 24'h000001};
        tbl[4]  = '{1'b0,1'b0,1'b1,1'b0, 24'h000003, 1'b1,1'b0,1'b0, 24'h000003};
        tbl[5]  = '{1'b1,1'b1,1'b0,1'b0, 24'h000004, 1'b0,1'b0,1'b0, 24'h000004};
        tbl[6]  = '{1'b1,1'b1,1'b0,1'b0, 24'h000004, 1'b1,1'b0,1'b1, 24'h000004};
        tbl[7]  = '{1'b1,1'b0,1'b0,1'b0, 24'h000005, 1'b1,1'b0,1'b0, 24'h000005};
        tbl[8]  = '{1'b0,1'b0,1'b1,1'b0, 24'h000005, 1'b1,1'b1,1'b0, 24'h000005};
        tbl[9]  = '{1'b1,1'b1,1'b0,1'b0, 24'h000006, 1'b0,1'b0,1'b0, 24'h000006};
        tbl[10] = '{1'b0,1'b0,1'b1,1'b0, 24'h000006, 1'b0,1'b0,1'b0, 24'h000006};
        tbl[11] = '{1'b1,1'b1,1'b1,1'b1, 24'h000000, 1'b0,1'b0,1'b0, 24'h000000};
        tbl[12] = '{1'b1,1'b0,1'b1,1'b0, 24'h000000, 1'b0,1'b0,1'b0, 24'h000000};
        tbl[13] = '{1'b0,1'b1,1'b1,1'b0, 24'h000000, 1'b1,1'b0,1'b1, 24'h000000};
        tbl[14] = '{1'b1,1'b1,1'b0,1'b1, 24'h000000, 1'b0,1'b0,1'b0, 24'h000000};

        repeat (2) @(posedge clock);
        #1;
        check_models();
        @(negedge clock);
        reset_n = 1'b1;

        // Directed table against fixed expectations for u0.
        for (int r = 0; r < 15; r++) begin
            cycle(tbl[r].t, tbl[r].ss, tbl[r].lp, tbl[r].cl);
            chk("tbl_time", r, time_o[0], tbl[r].exp_time);
            chk("tbl_run", r, 24'(run_o[0]), 24'(tbl[r].exp_run));
            chk("tbl_lapa", r, 24'(lapa_o[0]), 24'(tbl[r].exp_lapa));
            chk("tbl_restart", r, 24'(tr_o[0]), 24'(tbl[r].exp_tr));
            chk("tbl_disp", r, disp_o[0], tbl[r].exp_disp);
        end

        // Start then 150 ticks.
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("start_restart", 0, 24'(tr_o[0]), 24'h1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("restart_width", 0, 24'(tr_o[0]), 24'h0);
        run_ticks(150);
        chk("t150", 0, time_o[0], 24'h000150);
        chk("t150_run", 0, 24'(run_o[0]), 24'h1);

        // Carry chain through minutes, then u1 (09:59.99 full scale) wraps.
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        run_ticks(5999);
        chk("pre_minute", 0, time_o[0], 24'h005999);
        run_ticks(1);
        chk("minute_carry", 0, time_o[0], 24'h010000);
        run_ticks(53999);
        chk("full_scale", 1, time_o[1], 24'h095999);
        run_ticks(1);
        chk("wrap_time", 1, time_o[1], 24'h000000);
        chk("wrap_ovf", 1, 24'(ovf_o[1]), 24'h1);
        chk("ten_min", 0, time_o[0], 24'h100000);
        run_ticks(5);
        chk("ovf_sticky", 1, 24'(ovf_o[1]), 24'h1);
        chk("after_wrap", 1, time_o[1], 24'h000005);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_ovf", 1, 24'(ovf_o[1]), 24'h0);
        chk("clr_time", 1, time_o[1], 24'h000000);

        // Lap freeze at 00:03.27.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        run_ticks(327);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        run_ticks(20);
        chk("lap_disp", 0, disp_o[0], 24'h000327);
        chk("lap_time", 0, time_o[0], 24'h000347);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("lap_return", 0, disp_o[0], 24'h000347);

        // Asynchronous reset mid-count at 00:12.34.
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        run_ticks(1234);
        chk("pre_reset", 0, time_o[0], 24'h001234);
        tick_in = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_models();
        chk("async_time", 0, time_o[0], 24'h000000);
        chk("async_run", 0, 24'(run_o[0]), 24'h0);
        @(negedge clock);
        reset_n = 1'b1;
        run_ticks(10);
        chk("idle_ticks", 0, time_o[0], 24'h000000);

        // Random pulses against the model.
        for (int k = 0; k < 3000; k++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 14) == 0), 1'($urandom_range(0, 99) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
